// File: rtl/frog_controller.sv
// frog_controller
//   Owns the frog position for the road/river field. Turns WASD keycodes into
//   animated hops of STEP pixels (HOP_FRAMES frames each), clamps hops to the
//   640x480 field, and sequences scoring, death, respawn and game over from the
//   OR of all car collision outputs.
//
//   Build option: define FROG_INVULNERABLE_EN to ignore Car_Collision entirely
//   (debug/demo build; DYING and GAME_OVER become unreachable).
//
//   Ports:
//     frame_clk      in   1   frame clock, rising edge
//     Reset          in   1   synchronous, active-low
//     keycode        in   8   USB HID code (W/S/A/D, 0x00 none)
//     Car_Collision  in   1   OR of all car collision outputs
//     Frog_X/Frog_Y  out  11  frog top-left, px
//     Frog_Dir       out  2   facing: 0 up, 1 down, 2 left, 3 right
//     Lives          out  3   remaining lives
//     Score          out  8   goals reached, saturating at 255
//     Dead           out  1   high while dying
//     Game_Over      out  1   high once out of lives
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   READY     | idle at a grid cell, waiting for a fresh key press
//   HOP       | mid-hop, moving px per frame
//   SCORED    | reached the top row; bump score, respawn next edge
//   DYING     | hit by a car; Dead held for DEATH_FRAMES frames
//   GAME_OVER | no lives left; everything holds until Reset

module frog_controller #(
    parameter logic [10:0] FROG_START_X = 11'd300,
    parameter logic [10:0] FROG_START_Y = 11'd440,
    parameter logic [10:0] STEP         = 11'd40,
    parameter int          HOP_FRAMES   = 4,
    parameter int          DEATH_FRAMES = 30,
    parameter logic [2:0]  START_LIVES  = 3'd3
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [7:0]  keycode,
    input  logic        Car_Collision,
    output logic [10:0] Frog_X,
    output logic [10:0] Frog_Y,
    output logic [1:0]  Frog_Dir,
    output logic [2:0]  Lives,
    output logic [7:0]  Score,
    output logic        Dead,
    output logic        Game_Over
);

    localparam logic [10:0] PX    = STEP / 11'(HOP_FRAMES);
    localparam logic [10:0] MAX_X = 11'd640 - STEP;
    localparam logic [10:0] MAX_Y = 11'd480 - STEP;
    localparam int          HW    = $clog2(HOP_FRAMES + 1);
    localparam int          DW    = $clog2(DEATH_FRAMES + 1);

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef enum logic [2:0] {
        READY,
        HOP,
        SCORED,
        DYING,
        GAME_OVER
    } state_t;

    state_t          state, state_d;
    logic [7:0]      key_prev;
    logic [HW-1:0]   hop_cnt, hop_cnt_d;
    logic [DW-1:0]   death_cnt, death_cnt_d;
    logic [10:0]     x_d, y_d;
    logic [1:0]      dir_d;
    logic [2:0]      lives_d;
    logic [7:0]      score_d;

    logic            collide;
    logic            key_valid;
    logic [1:0]      key_dir;
    logic [1:0]      mv_dir;
    logic [10:0]     mv_x, mv_y;
    logic            target_ok;

`ifdef FROG_INVULNERABLE_EN
    assign collide = 1'b0;
`else
    assign collide = Car_Collision;
`endif

    assign Dead      = (state == DYING);
    assign Game_Over = (state == GAME_OVER);

    always_comb begin
        key_valid = 1'b1;
        key_dir   = 2'd0;
        case (keycode)
            KEY_W:   key_dir = 2'd0;
            KEY_S:   key_dir = 2'd1;
            KEY_A:   key_dir = 2'd2;
            KEY_D:   key_dir = 2'd3;
            default: key_valid = 1'b0;
        endcase
    end

    // Full-hop target check: the hop is refused if it would leave the field.
    // Down/right sums cannot overflow 11 bits since positions stay <= 600.
    always_comb begin
        target_ok = 1'b0;
        case (key_dir)
            2'd0: target_ok = (Frog_Y >= STEP);
            2'd1: target_ok = ((Frog_Y + STEP) <= MAX_Y);
            2'd2: target_ok = (Frog_X >= STEP);
            2'd3: target_ok = ((Frog_X + STEP) <= MAX_X);
        endcase
    end

    // One-frame move. On the accepting edge the new key gives the direction;
    // during the hop Frog_Dir already holds it.
    always_comb begin
        mv_dir = (state == READY) ? key_dir : Frog_Dir;
        mv_x   = Frog_X;
        mv_y   = Frog_Y;
        case (mv_dir)
            2'd0: mv_y = Frog_Y - PX;
            2'd1: mv_y = Frog_Y + PX;
            2'd2: mv_x = Frog_X - PX;
            2'd3: mv_x = Frog_X + PX;
        endcase
    end

    always_comb begin
        state_d     = state;
        x_d         = Frog_X;
        y_d         = Frog_Y;
        dir_d       = Frog_Dir;
        lives_d     = Lives;
        score_d     = Score;
        hop_cnt_d   = hop_cnt;
        death_cnt_d = death_cnt;

        case (state)
            READY: begin
                if (collide) begin
                    state_d     = DYING;
                    lives_d     = (Lives != 3'd0) ? Lives - 3'd1 : 3'd0;
                    death_cnt_d = DW'(DEATH_FRAMES - 1);
                end else if (key_valid && (key_prev == 8'h00)) begin
                    dir_d = key_dir;
                    if (target_ok) begin
                        x_d       = mv_x;
                        y_d       = mv_y;
                        hop_cnt_d = HW'(HOP_FRAMES - 1);
                        if (HOP_FRAMES == 1)
                            state_d = (mv_y == 11'd0) ? SCORED : READY;
                        else
                            state_d = HOP;
                    end
                end
            end

            HOP: begin
                if (collide) begin
                    state_d     = DYING;
                    lives_d     = (Lives != 3'd0) ? Lives - 3'd1 : 3'd0;
                    death_cnt_d = DW'(DEATH_FRAMES - 1);
                end else begin
                    x_d       = mv_x;
                    y_d       = mv_y;
                    hop_cnt_d = hop_cnt - HW'(1);
                    // hop_cnt counts moves still to make, this one included
                    if (hop_cnt == HW'(1))
                        state_d = (mv_y == 11'd0) ? SCORED : READY;
                end
            end

            SCORED: begin
                score_d = (Score != 8'hFF) ? Score + 8'd1 : Score;
                x_d     = FROG_START_X;
                y_d     = FROG_START_Y;
                state_d = READY;
            end

            DYING: begin
                if (death_cnt == DW'(0)) begin
                    if (Lives == 3'd0) begin
                        state_d = GAME_OVER;
                    end else begin
                        x_d     = FROG_START_X;
                        y_d     = FROG_START_Y;
                        dir_d   = 2'd0;
                        state_d = READY;
                    end
                end else begin
                    death_cnt_d = death_cnt - DW'(1);
                end
            end

            GAME_OVER: begin
                state_d = GAME_OVER;
            end

            default: state_d = READY;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state     <= READY;
            Frog_X    <= FROG_START_X;
            Frog_Y    <= FROG_START_Y;
            Frog_Dir  <= 2'd0;
            Lives     <= START_LIVES;
            Score     <= 8'd0;
            key_prev  <= 8'h00;
            hop_cnt   <= '0;
            death_cnt <= '0;
        end else begin
            state     <= state_d;
            Frog_X    <= x_d;
            Frog_Y    <= y_d;
            Frog_Dir  <= dir_d;
            Lives     <= lives_d;
            Score     <= score_d;
            key_prev  <= keycode;
            hop_cnt   <= hop_cnt_d;
            death_cnt <= death_cnt_d;
        end
    end

endmodule
